// File: rtl/spi_master_dma_if.sv
// spi_master_dma_if: the signal bundle around the SPI block-transfer master.
//   control : start, op, cpol, cpha, len  (from the command engine)
//             busy, done                  (status back to the command engine)
//   memory  : address, data_out, wr       (to the byte memory)
//             data_in                     (combinational read data)
//   spi     : sclk, mosi, cs_n            (to the card)
//             miso                        (from the card)
// modport master is taken by the SPI master; modport slave is the view of
// everything around it (command engine, memory and card together).
interface spi_master_dma_if #(
  parameter int MEM_DEPTH = 512
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int LW = $clog2(MEM_DEPTH + 1);

  logic          start;
  logic [1:0]    op;
  logic          cpol;
  logic          cpha;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;

  logic [AW-1:0] address;
  logic [7:0]    data_in;
  logic [7:0]    data_out;
  logic          wr;

  logic          sclk;
  logic          mosi;
  logic          miso;
  logic          cs_n;

  modport master (
    input  start, op, cpol, cpha, len, data_in, miso,
    output busy, done, address, data_out, wr, sclk, mosi, cs_n
  );

  modport slave (
    output start, op, cpol, cpha, len, data_in, miso,
    input  busy, done, address, data_out, wr, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_dma.sv
// spi_master_dma: moves len bytes between a local byte memory and an SPI
// slave. Supports all four CPOL/CPHA modes, a programmable SCLK divider,
// chip-select guard time and three transfer modes (TX, RX, exchange).
// Ports:
//   clk  system clock, single domain
//   rst  asynchronous active-high reset
//   bus  spi_master_dma_if.master: start/op/cpol/cpha/len in, busy/done out;
//        address/data_out/wr to memory, data_in from memory;
//        sclk/mosi/cs_n to the slave, miso from the slave
module spi_master_dma #(
  parameter int MEM_DEPTH = 512,
  parameter int CLK_DIV   = 2,
  parameter int CS_GUARD  = 1
) (
  input  logic             clk,
  input  logic             rst,
  spi_master_dma_if.master bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int LW = $clog2(MEM_DEPTH + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_GUARD > 1) ? $clog2(CS_GUARD) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'((CLK_DIV > 1) ? CLK_DIV - 1 : 0);
  localparam logic [GW-1:0] GUARD_LAST = GW'((CS_GUARD > 1) ? CS_GUARD - 1 : 0);

  localparam logic [1:0] OP_TX   = 2'b00;
  localparam logic [1:0] OP_RX   = 2'b01;
  localparam logic [1:0] OP_XCHG = 2'b10;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]    state;
  logic [1:0]    op_q;
  logic          cpol_q;
  logic          cpha_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] byte_cnt;
  logic [GW-1:0] guard_cnt;
  logic [DW-1:0] div_cnt;
  logic [3:0]    edge_cnt;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;

  logic [AW-1:0] address_q;
  logic [7:0]    data_out_q;
  logic          wr_q;
  logic          sclk_q;
  logic          mosi_q;
  logic          cs_n_q;
  logic          busy_q;
  logic          done_q;

  assign bus.address  = address_q;
  assign bus.data_out = data_out_q;
  assign bus.wr       = wr_q;
  assign bus.sclk     = sclk_q;
  assign bus.mosi     = mosi_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  logic       div_tick;
  logic       last_edge;
  logic       sample_now;
  logic       shift_now;
  logic       store_en;
  logic [7:0] load_byte;
  logic [7:0] rx_sampled;

  // Edge bookkeeping: even edge_cnt values are leading SCLK edges, odd ones
  // trailing. cpha=0 samples on leading edges, cpha=1 on trailing edges;
  // the opposite edges shift, except the final edge of a byte (a trailing
  // edge), after which nothing further is driven for this byte.
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no latch can be inferred.
    div_tick   = (div_cnt == DIV_LAST);
    last_edge  = (edge_cnt == 4'd15);
    sample_now = (~edge_cnt[0]) ^ cpha_q;
    shift_now  = ~sample_now & ~last_edge;
    store_en   = (op_q == OP_RX) || (op_q == OP_XCHG);
    load_byte  = (op_q == OP_RX) ? 8'hFF : bus.data_in;
    rx_sampled = {rx_sr[6:0], bus.miso};
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= OP_TX;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      len_q      <= '0;
      byte_cnt   <= '0;
      guard_cnt  <= '0;
      div_cnt    <= '0;
      edge_cnt   <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      address_q  <= '0;
      data_out_q <= '0;
      wr_q       <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b1;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.len == '0) begin
              // Empty transfer: report completion without touching the bus.
              state <= S_DONE;
            end else begin
              op_q      <= bus.op;
              cpol_q    <= bus.cpol;
              cpha_q    <= bus.cpha;
              len_q     <= bus.len;
              byte_cnt  <= '0;
              guard_cnt <= '0;
              address_q <= '0;
              sclk_q    <= bus.cpol;
              cs_n_q    <= 1'b0;
              state     <= S_SETUP;
            end
          end
        end

        S_SETUP: begin
          if (guard_cnt == GUARD_LAST) begin
            state <= S_LOAD;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end

        S_LOAD: begin
          // cpha=0 needs the MSB on the wire before the first (sampling)
          // edge; cpha=1 drives it on that first edge instead.
          if (!cpha_q) begin
            mosi_q <= load_byte[7];
            tx_sr  <= {load_byte[6:0], 1'b0};
          end else begin
            tx_sr  <= load_byte;
          end
          edge_cnt <= '0;
          div_cnt  <= '0;
          state    <= S_SHIFT;
        end

        S_SHIFT: begin
          if (div_tick) begin
            div_cnt  <= '0;
            sclk_q   <= ~sclk_q;
            edge_cnt <= edge_cnt + 4'd1;
            if (sample_now) begin
              rx_sr <= rx_sampled;
            end
            if (shift_now) begin
              mosi_q <= tx_sr[7];
              tx_sr  <= {tx_sr[6:0], 1'b0};
            end
            if (last_edge) begin
              // Present the write during STORE so it lands at the address
              // of the byte just finished, before address advances.
              // The final edge is a sampling edge only for cpha=1.
              if (store_en) begin
                data_out_q <= cpha_q ? rx_sampled : rx_sr;
              end
              wr_q  <= store_en;
              state <= S_STORE;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        S_STORE: begin
          wr_q <= 1'b0;
          if (byte_cnt + LW'(1) == len_q) begin
            guard_cnt <= '0;
            state     <= S_HOLD;
          end else begin
            byte_cnt  <= byte_cnt + LW'(1);
            address_q <= address_q + AW'(1);
            state     <= S_LOAD;
          end
        end

        S_HOLD: begin
          if (guard_cnt == GUARD_LAST) begin
            cs_n_q <= 1'b1;
            mosi_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end

        S_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_dma.sv
// tb_spi_master_dma: directed self-checking bench for spi_master_dma.
// A monitor compares memory writes and MOSI bytes against expectation queues
// filled by the stimulus; a simple slave model serves MISO bytes in CPHA=1
// modes, or MISO is looped back to MOSI.
module tb_spi_master_dma;
  localparam int MEM_DEPTH = 512;
  localparam int CLK_DIV   = 2;
  localparam int CS_GUARD  = 1;
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int LW = $clog2(MEM_DEPTH + 1);

  localparam logic [1:0] OP_TX   = 2'b00;
  localparam logic [1:0] OP_RX   = 2'b01;
  localparam logic [1:0] OP_XCHG = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_dma_if #(.MEM_DEPTH(MEM_DEPTH)) bus ();

  spi_master_dma #(
    .MEM_DEPTH(MEM_DEPTH),
    .CLK_DIV  (CLK_DIV),
    .CS_GUARD (CS_GUARD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  // NOTE: the memory has no reset; the bench loads every location it reads before use.
  logic [7:0] mem [MEM_DEPTH];
  assign bus.data_in = mem[bus.address];
  always @(posedge clk) begin
    if (bus.wr) mem[bus.address] <= bus.data_out;
  end

  logic loop_en    = 1'b0;
  logic slave_miso = 1'b1;
  logic tb_cpol    = 1'b0;
  logic mon_mosi   = 1'b0;
  assign bus.miso = loop_en ? bus.mosi : slave_miso;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard queues and slave data.
  logic [7:0]    exp_mosi[$];
  logic [AW-1:0] exp_wr_addr[$];
  logic [7:0]    exp_wr_data[$];
  logic [7:0]    slave_q[$];

  // Monitor counters and history.
  int   rise_cnt = 0, toggle_cnt = 0, done_cnt = 0, wr_cnt = 0;
  int   cs_low_cnt = 0, cs_rise_cnt = 0, mosi_low_cnt = 0;
  logic sclk_prev = 1'b0, cs_prev = 1'b1;
  logic [2:0] mbit_cnt = '0, slave_bit = '0;
  logic [7:0] mbyte = '0, slave_sr = '0;

  always @(negedge clk) begin
    sclk_prev <= bus.sclk;
    cs_prev   <= bus.cs_n;
    if (rst) begin
      mbit_cnt  <= '0;
      slave_bit <= '0;
    end else begin
      if (bus.done)              done_cnt     <= done_cnt + 1;
      if (!bus.cs_n)             cs_low_cnt   <= cs_low_cnt + 1;
      if (bus.cs_n && !cs_prev)  cs_rise_cnt  <= cs_rise_cnt + 1;
      if (bus.sclk != sclk_prev) toggle_cnt   <= toggle_cnt + 1;
      if (!bus.cs_n && !bus.mosi) mosi_low_cnt <= mosi_low_cnt + 1;

      if (bus.wr) begin
        wr_cnt <= wr_cnt + 1;
        if (exp_wr_addr.size() > 0) begin
          check("wr_addr", 32'(bus.address), 32'(exp_wr_addr.pop_front()));
          check("wr_data", 32'(bus.data_out), 32'(exp_wr_data.pop_front()));
        end
      end

      if (!bus.cs_n && !cs_prev && bus.sclk && !sclk_prev) begin
        rise_cnt <= rise_cnt + 1;
        if (mon_mosi) begin
          if (mbit_cnt == 3'd7) begin
            if (exp_mosi.size() > 0)
              check("mosi_byte", 32'({mbyte[6:0], bus.mosi}), 32'(exp_mosi.pop_front()));
          end else begin
            mbyte <= {mbyte[6:0], bus.mosi};
          end
          mbit_cnt <= mbit_cnt + 3'd1;
        end
      end

      // Slave: present the next MISO bit on each leading edge.
      if (!bus.cs_n && !cs_prev && bus.sclk != sclk_prev && sclk_prev == tb_cpol) begin
        if (slave_bit == 3'd0) begin
          if (slave_q.size() > 0) begin
            slave_miso <= slave_q[0][7];
            slave_sr   <= {slave_q[0][6:0], 1'b0};
            void'(slave_q.pop_front());
            slave_bit  <= 3'd1;
          end
        end else begin
          slave_miso <= slave_sr[7];
          slave_sr   <= {slave_sr[6:0], 1'b0};
          slave_bit  <= slave_bit + 3'd1;
        end
      end
    end
  end

  int s_rise, s_toggle, s_done, s_wr, s_cs_low, s_cs_rise, s_mosi_low;

  task automatic snap();
    s_rise = rise_cnt;  s_toggle = toggle_cnt; s_done = done_cnt; s_wr = wr_cnt;
    s_cs_low = cs_low_cnt; s_cs_rise = cs_rise_cnt; s_mosi_low = mosi_low_cnt;
  endtask

  task automatic start_xfer(input logic [1:0] o, input logic pol, input logic pha,
                            input logic [LW-1:0] n);
    bus.op = o; bus.cpol = pol; bus.cpha = pha; bus.len = n;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic sclk_hi;
    bus.start = 1'b0; bus.op = OP_TX; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.len = '0;
    repeat (3) @(negedge clk);

    // Reset values, checked while rst is still high.
    check("rst_sclk",     32'(bus.sclk),     32'd0);
    check("rst_cs_n",     32'(bus.cs_n),     32'd1);
    check("rst_mosi",     32'(bus.mosi),     32'd1);
    check("rst_wr",       32'(bus.wr),       32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_address",  32'(bus.address),  32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // TX, mode 0, three bytes.
    mem[0] = 8'hAA; mem[1] = 8'h01; mem[2] = 8'h02;
    exp_mosi.push_back(8'hAA); exp_mosi.push_back(8'h01); exp_mosi.push_back(8'h02);
    mon_mosi = 1'b1; tb_cpol = 1'b0;
    snap();
    start_xfer(OP_TX, 1'b0, 1'b0, LW'(3));
    check("tx_busy", 32'(bus.busy), 32'd1);
    wait_done(2000);
    check("tx_rises",     32'(rise_cnt - s_rise),       32'd24);
    check("tx_wr_count",  32'(wr_cnt - s_wr),           32'd0);
    check("tx_done_once", 32'(done_cnt - s_done),       32'd1);
    check("tx_cs_rise",   32'(cs_rise_cnt - s_cs_rise), 32'd1);
    check("tx_mosi_left", 32'(exp_mosi.size()),         32'd0);
    check("tx_addr_hold", 32'(bus.address),             32'd2);
    check("tx_busy_end",  32'(bus.busy),                32'd0);
    mon_mosi = 1'b0;

    // RX, mode 3, slave sends 5A then C3.
    tb_cpol = 1'b1;
    slave_q.push_back(8'h5A); slave_q.push_back(8'hC3);
    exp_wr_addr.push_back(AW'(0)); exp_wr_data.push_back(8'h5A);
    exp_wr_addr.push_back(AW'(1)); exp_wr_data.push_back(8'hC3);
    snap();
    start_xfer(OP_RX, 1'b1, 1'b1, LW'(2));
    wait_done(2000);
    check("rx_wr_count",  32'(wr_cnt - s_wr),             32'd2);
    check("rx_mem0",      32'(mem[0]),                    32'h5A);
    check("rx_mem1",      32'(mem[1]),                    32'hC3);
    check("rx_mosi_high", 32'(mosi_low_cnt - s_mosi_low), 32'd0);
    check("rx_sclk_idle", 32'(bus.sclk),                  32'd1);
    check("rx_done_once", 32'(done_cnt - s_done),         32'd1);

    // Exchange, mode 1, MISO looped back to MOSI.
    tb_cpol = 1'b0; loop_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem[i] = 8'(8'h10 * (i + 1));
      exp_wr_addr.push_back(AW'(i));
      exp_wr_data.push_back(8'(8'h10 * (i + 1)));
    end
    snap();
    start_xfer(OP_XCHG, 1'b0, 1'b1, LW'(4));
    wait_done(2000);
    check("xc_wr_count", 32'(wr_cnt - s_wr),      32'd4);
    check("xc_wr_left",  32'(exp_wr_addr.size()), 32'd0);
    check("xc_addr_hold", 32'(bus.address),       32'd3);
    for (int i = 0; i < 4; i++) check("xc_mem", 32'(mem[i]), 32'(8'h10 * (i + 1)));
    loop_en = 1'b0;

    // Start pulsed again while busy must be ignored.
    mem[0] = 8'hAA; mem[1] = 8'h01;
    exp_mosi.push_back(8'hAA); exp_mosi.push_back(8'h01);
    mon_mosi = 1'b1;
    snap();
    start_xfer(OP_TX, 1'b0, 1'b0, LW'(2));
    repeat (10) @(negedge clk);
    start_xfer(OP_RX, 1'b0, 1'b0, LW'(1));
    wait_done(2000);
    repeat (80) @(negedge clk);
    check("bz_done_once", 32'(done_cnt - s_done), 32'd1);
    check("bz_rises",     32'(rise_cnt - s_rise), 32'd16);
    check("bz_wr_count",  32'(wr_cnt - s_wr),     32'd0);
    check("bz_mosi_left", 32'(exp_mosi.size()),   32'd0);
    check("bz_busy",      32'(bus.busy),          32'd0);
    mon_mosi = 1'b0;

    // Zero-length start.
    snap();
    start_xfer(OP_TX, 1'b0, 1'b0, LW'(0));
    check("z_busy_c1", 32'(bus.busy), 32'd1);
    check("z_done_c1", 32'(bus.done), 32'd0);
    @(negedge clk);
    check("z_done_c2", 32'(bus.done), 32'd1);
    @(negedge clk);
    check("z_done_c3", 32'(bus.done), 32'd0);
    check("z_cs_low",  32'(cs_low_cnt - s_cs_low), 32'd0);
    check("z_toggles", 32'(toggle_cnt - s_toggle), 32'd0);
    check("z_done_once", 32'(done_cnt - s_done),   32'd1);

    // Reset in the middle of byte 1 of a mode-2 transfer, with sclk high.
    tb_cpol = 1'b1;
    start_xfer(OP_TX, 1'b1, 1'b0, LW'(3));
    repeat (45) @(negedge clk);
    sclk_hi = 1'b0;
    for (int i = 0; i < 10 && !sclk_hi; i++) begin
      if (bus.sclk && !bus.cs_n) sclk_hi = 1'b1;
      else @(negedge clk);
    end
    check("ab_sclk_high", 32'(sclk_hi), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ab_cs_n", 32'(bus.cs_n), 32'd1);
    check("ab_sclk", 32'(bus.sclk), 32'd0);
    check("ab_busy", 32'(bus.busy), 32'd0);
    check("ab_wr",   32'(bus.wr),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_mosi.delete(); exp_wr_addr.delete(); exp_wr_data.delete(); slave_q.delete();
    tb_cpol = 1'b0;
    @(negedge clk);

    // Recovery: one-byte TX of 0x81.
    mem[0] = 8'h81;
    exp_mosi.push_back(8'h81);
    mon_mosi = 1'b1;
    snap();
    start_xfer(OP_TX, 1'b0, 1'b0, LW'(1));
    wait_done(2000);
    check("rc_rises",     32'(rise_cnt - s_rise),       32'd8);
    check("rc_wr_count",  32'(wr_cnt - s_wr),           32'd0);
    check("rc_done_once", 32'(done_cnt - s_done),       32'd1);
    check("rc_mosi_left", 32'(exp_mosi.size()),         32'd0);
    check("rc_cs_rise",   32'(cs_rise_cnt - s_cs_rise), 32'd1);
    check("rc_address",   32'(bus.address),             32'd0);
    check("rc_mosi_idle", 32'(bus.mosi),                32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_master_dma.md
Name: spi_master_dma

Overview:
- Parametrised successor to the SD-card SPI controller: an SPI master that moves a block of bytes between a local byte memory and an SPI slave.
- Adds a programmable SCLK divider, all four CPOL/CPHA modes, chip-select sequencing, and three transfer modes: TX, RX and full-duplex exchange.
- Sits between the SD command/data engine (which owns the memory and issues start) and the card pins.

Parameters:
- MEM_DEPTH, 512, bytes in the attached memory; sets the address width AW = $clog2(MEM_DEPTH) and the length width LW = $clog2(MEM_DEPTH+1).
- CLK_DIV, 2, clk cycles per SCLK half-period; legal range 1 and above.
- CS_GUARD, 1, clk cycles cs_n is held low before the first SCLK edge and after the last SCLK edge.

Ports:
- clk  in  1  system clock; every flop is in this domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- op  in  2  00 = TX (drive memory bytes, discard MISO); 01 = RX (drive 0xFF, store MISO); 10 = XCHG (drive and store at the same address); 11 = reserved, treated as TX.
- cpol  in  1  SCLK idle level; latched at start.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at start.
- len  in  LW  number of bytes; latched at start.
- address  out  AW  memory byte address.
- data_in  in  8  memory read data, combinational from address.
- data_out  out  8  memory write data.
- wr  out  1  one-cycle write strobe for data_out at address.
- sclk  out  1  SPI clock.
- mosi  out  1  SPI data out, MSB first.
- miso  in  1  SPI data in; the slave is treated as synchronous to clk, no synchroniser.
- cs_n  out  1  active-low chip select.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: sclk=0, cs_n=1, mosi=1, wr=0, done=0, busy=0, address=0, data_out=0, state=IDLE, latched cpol/cpha=0. Asserting rst mid-transfer aborts immediately; no partial write completes.
- States: IDLE, SETUP, LOAD, SHIFT, STORE, HOLD, DONE.
- IDLE, start=1 and len=0: go to DONE; done pulses on the 2nd cycle after start; cs_n never falls.
- IDLE, start=1 and len>0: latch op, cpol, cpha and len; set address=0, sclk=cpol, cs_n=0, busy=1; go to SETUP.
- start is ignored while busy.
- SETUP: wait CS_GUARD cycles, then go to LOAD.
- LOAD (1 cycle): shift register <= data_in for TX/XCHG, 0xFF for RX; bit count <= 0. For cpha=0, mosi presents the MSB at the end of this cycle.
- SHIFT: SCLK toggles every CLK_DIV cycles, giving 16 edges per byte.
  - cpha=0: sample miso on each leading edge; shift mosi on each trailing edge except the final one.
  - cpha=1: shift mosi on each leading edge; sample on each trailing edge.
  - After the 16th edge, sclk is at the cpol idle level; go to STORE.
- STORE (1 cycle):
  - RX/XCHG: data_out = received byte, wr=1 at the current address.
  - TX: wr stays 0.
  - If the byte count equals len, go to HOLD. Otherwise increment address and go to LOAD, so the next byte starts with no added idle beyond LOAD.
- HOLD: wait CS_GUARD cycles, set cs_n=1, go to DONE.
- DONE (1 cycle): done=1, busy=0, go to IDLE. address holds len-1 until the next start.
- mosi returns to 1 whenever cs_n=1.
- Byte count wraps never: len is at most MEM_DEPTH, and address never exceeds MEM_DEPTH-1.

Test Plan:
- TX, mode 0, CLK_DIV=2, len=3, mem={AA,01,02}: mosi sampled on sclk rising edges gives AA 01 02; exactly 24 rising edges; wr never asserts; done pulses once; cs_n is low throughout the bytes.
- RX, mode 3 (cpol=1, cpha=1), len=2, slave drives 5A then C3: mosi stays 1; wr pulses twice, writing mem[0]=5A and mem[1]=C3; sclk idles at 1.
- XCHG, mode 1, miso looped to mosi, len=4, mem={10,20,30,40}: memory is unchanged after done; 4 wr pulses at addresses 0..3.
- len=0 start: done pulses on the 2nd cycle after start; cs_n stays 1; no sclk edges.
- start pulsed again during busy on a len=2 TX: it is ignored; only one done pulse occurs.
- rst asserted mid-bit of byte 1: on the same edge, cs_n=1, sclk=0, busy=0, wr=0. A following len=1 TX of 0x81 then completes correctly.
